// File: rtl/board_state_engine.sv
// ---------------------------------------------------------------------------
// board_state_engine
//   Keeps the board state for an N x N tic-tac-toe game.
//   - Accepts one move at a time and rejects illegal ones.
//   - Writes the mover's marker into the chosen cell.
//   - Scans every line for a win, one line per clock.
//   - Tracks the turn, the move count and the game-over/draw result.
//
// Ports
//   clk, clr       clock, synchronous active-high reset
//   move_valid     move request, held by the requester until ack or reject
//   move_idx       row-major cell index (row*BOARD_DIM+col)
//   move_ready     high only in IDLE
//   move_ack       1-cycle pulse: move accepted and written
//   move_reject    1-cycle pulse: move illegal, board unchanged
//   board_flat     cell i at [2i+1:2i] (00 blank, 01 player 1, 10 player 2)
//   player_turn    0 = player 1 to move, 1 = player 2 to move
//   move_count     accepted moves since reset
//   game_over      high in OVER
//   winner, draw   result, valid while game_over is high
//
// Handshake: a request (move_valid) is sampled only on an edge where the
//   engine is in IDLE and no ack/reject pulse is currently showing.
//   - Exactly one of move_ack / move_reject answers it on the next cycle.
//   - The requester drops move_valid once it sees that answer.
//   - In SCAN the request is ignored.
//   - In OVER every sampled request is rejected.
// ---------------------------------------------------------------------------
module board_state_engine #(
  parameter int  BOARD_DIM = 3,
  localparam int CELLS     = BOARD_DIM * BOARD_DIM,
  localparam int IDX_W     = $clog2(CELLS),
  localparam int CNT_W     = $clog2(CELLS + 1)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               move_valid,
  input  logic [IDX_W-1:0]   move_idx,
  output logic               move_ready,
  output logic               move_ack,
  output logic               move_reject,
  output logic [2*CELLS-1:0] board_flat,
  output logic               player_turn,
  output logic [CNT_W-1:0]   move_count,
  output logic               game_over,
  output logic [1:0]         winner,
  output logic               draw
);

  localparam int LINES = 2 * BOARD_DIM + 2;
  localparam int LP_W  = $clog2(LINES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2*CELLS-1:0] board_q, board_d;
  logic               turn_q, turn_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [LP_W-1:0]    line_ptr_q, line_ptr_d;
  logic               win_q, win_d;
  logic               ack_q, ack_d;
  logic               reject_q, reject_d;
  logic [1:0]         winner_q, winner_d;
  logic               draw_q, draw_d;

  logic [1:0] marker;
  logic [1:0] sel_cell;
  logic       in_range;
  logic       legal;
  logic       req_ok;
  logic       line_hit;
  logic       last_line;

  // During SCAN, turn_q still names the player who just moved.
  assign marker = turn_q ? 2'b10 : 2'b01;

  // Ignore a request while an answer pulse is showing.
  // This keeps each pulse at exactly one cycle even if move_valid lags.
  assign req_ok    = move_valid && !ack_q && !reject_q;
  assign in_range  = int'(move_idx) < CELLS;
  assign legal     = in_range && (sel_cell == 2'b00);
  assign last_line = (line_ptr_q == LP_W'(LINES - 1));

  // Contents of the requested cell (00 when the index is out of range).
  always_comb begin
    sel_cell = 2'b00;
    for (int i = 0; i < CELLS; i++) begin
      if (move_idx == IDX_W'(i)) sel_cell = board_q[2*i +: 2];
    end
  end

  // Evaluate the line selected by line_ptr_q against the mover's marker.
  // Lines are ordered: rows, columns, main diagonal, anti-diagonal.
  always_comb begin
    int         p;
    int         c;
    logic [1:0] cell_v;
    p        = int'(line_ptr_q);
    c        = 0;
    cell_v   = 2'b00;
    line_hit = 1'b1;
    for (int k = 0; k < BOARD_DIM; k++) begin
      if (p < BOARD_DIM)            c = p * BOARD_DIM + k;
      else if (p < 2 * BOARD_DIM)   c = k * BOARD_DIM + (p - BOARD_DIM);
      else if (p == 2 * BOARD_DIM)  c = k * BOARD_DIM + k;
      else                          c = k * BOARD_DIM + (BOARD_DIM - 1 - k);
      cell_v = 2'(board_q >> (2 * c));
      if (cell_v != marker) line_hit = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    board_d    = board_q;
    turn_d     = turn_q;
    count_d    = count_q;
    line_ptr_d = line_ptr_q;
    win_d      = win_q;
    ack_d      = 1'b0;
    reject_d   = 1'b0;
    winner_d   = winner_q;
    draw_d     = draw_q;
    case (state_q)
      ST_IDLE: begin
        if (req_ok) begin
          if (legal) begin
            for (int i = 0; i < CELLS; i++) begin
              if (move_idx == IDX_W'(i)) board_d[2*i +: 2] = marker;
            end
            count_d    = count_q + CNT_W'(1);
            line_ptr_d = '0;
            win_d      = 1'b0;
            ack_d      = 1'b1;
            state_d    = ST_SCAN;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      ST_SCAN: begin
        // No early exit: all lines are scanned, so latency is fixed.
        win_d      = win_q | line_hit;
        line_ptr_d = line_ptr_q + LP_W'(1);
        if (last_line) begin
          line_ptr_d = '0;
          if (win_d) begin
            state_d  = ST_OVER;
            winner_d = marker;
            draw_d   = 1'b0;
          end else if (count_q == CNT_W'(CELLS)) begin
            state_d  = ST_OVER;
            winner_d = 2'b00;
            draw_d   = 1'b1;
          end else begin
            turn_d  = ~turn_q;
            state_d = ST_IDLE;
          end
        end
      end
      ST_OVER: begin
        if (req_ok) reject_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= ST_IDLE;
      board_q    <= '0;
      turn_q     <= 1'b0;
      count_q    <= '0;
      line_ptr_q <= '0;
      win_q      <= 1'b0;
      ack_q      <= 1'b0;
      reject_q   <= 1'b0;
      winner_q   <= 2'b00;
      draw_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      board_q    <= board_d;
      turn_q     <= turn_d;
      count_q    <= count_d;
      line_ptr_q <= line_ptr_d;
      win_q      <= win_d;
      ack_q      <= ack_d;
      reject_q   <= reject_d;
      winner_q   <= winner_d;
      draw_q     <= draw_d;
    end
  end

  assign move_ready  = (state_q == ST_IDLE);
  assign move_ack    = ack_q;
  assign move_reject = reject_q;
  assign board_flat  = board_q;
  assign player_turn = turn_q;
  assign move_count  = count_q;
  assign game_over   = (state_q == ST_OVER);
  assign winner      = winner_q;
  assign draw        = draw_q;

endmodule

// File: tb/tb_board_state_engine.sv
module tb_board_state_engine;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr;
  logic       tb_valid;
  logic [3:0] tb_idx;
  logic       use4;

  // N=3 instance
  logic        v3, rdy3, ack3, rej3, t3, go3, d3;
  logic [3:0]  i3, c3;
  logic [17:0] b3;
  logic [1:0]  w3;
  // N=4 instance
  logic        v4, rdy4, ack4, rej4, t4, go4, d4;
  logic [3:0]  i4;
  logic [4:0]  c4;
  logic [31:0] b4;
  logic [1:0]  w4;

  assign v3 = tb_valid & ~use4;
  assign v4 = tb_valid & use4;
  assign i3 = tb_idx;
  assign i4 = tb_idx;

  board_state_engine #(.BOARD_DIM(3)) dut3 (
    .clk(clk), .clr(clr), .move_valid(v3), .move_idx(i3),
    .move_ready(rdy3), .move_ack(ack3), .move_reject(rej3),
    .board_flat(b3), .player_turn(t3), .move_count(c3),
    .game_over(go3), .winner(w3), .draw(d3)
  );

  board_state_engine #(.BOARD_DIM(4)) dut4 (
    .clk(clk), .clr(clr), .move_valid(v4), .move_idx(i4),
    .move_ready(rdy4), .move_ack(ack4), .move_reject(rej4),
    .board_flat(b4), .player_turn(t4), .move_count(c4),
    .game_over(go4), .winner(w4), .draw(d4)
  );

  // Selected-instance view
  logic        s_rdy, s_ack, s_rej, s_turn, s_go, s_draw;
  logic [7:0]  s_count;
  logic [1:0]  s_win;
  logic [63:0] s_board;
  assign s_rdy   = use4 ? rdy4 : rdy3;
  assign s_ack   = use4 ? ack4 : ack3;
  assign s_rej   = use4 ? rej4 : rej3;
  assign s_turn  = use4 ? t4 : t3;
  assign s_go    = use4 ? go4 : go3;
  assign s_draw  = use4 ? d4 : d3;
  assign s_count = use4 ? 8'(c4) : 8'(c3);
  assign s_win   = use4 ? w4 : w3;
  assign s_board = use4 ? 64'(b4) : 64'(b3);

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=response", name);
  endtask

  // ---------------- reference model ----------------
  // The board is an int array: 0 blank, 1 player 1, 2 player 2.
  // A win is checked over the whole board after every accepted move.
  int mb[64];
  int mn, mcells, mturn, mcount, mover, mwinner, mdraw;

  function automatic void model_reset(input int n);
    for (int i = 0; i < 64; i++) mb[i] = 0;
    mn = n; mcells = n * n;
    mturn = 0; mcount = 0; mover = 0; mwinner = 0; mdraw = 0;
  endfunction

  function automatic bit model_wins(input int m);
    bit all_m;
    for (int r = 0; r < mn; r++) begin
      all_m = 1;
      for (int k = 0; k < mn; k++) if (mb[r*mn+k] != m) all_m = 0;
      if (all_m) return 1;
    end
    for (int c = 0; c < mn; c++) begin
      all_m = 1;
      for (int k = 0; k < mn; k++) if (mb[k*mn+c] != m) all_m = 0;
      if (all_m) return 1;
    end
    all_m = 1;
    for (int k = 0; k < mn; k++) if (mb[k*mn+k] != m) all_m = 0;
    if (all_m) return 1;
    all_m = 1;
    for (int k = 0; k < mn; k++) if (mb[k*mn+mn-1-k] != m) all_m = 0;
    return all_m;
  endfunction

  function automatic int model_move(input int idx);
    int m;
    if (mover != 0 || idx >= mcells || mb[idx] != 0) return 0;
    m = mturn + 1;
    mb[idx] = m;
    mcount++;
    if (model_wins(m)) begin
      mover = 1; mwinner = m;
    end else if (mcount == mcells) begin
      mover = 1; mdraw = 1;
    end else begin
      mturn = 1 - mturn;
    end
    return 1;
  endfunction

  function automatic logic [63:0] model_board();
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < mcells; i++) r[2*i +: 2] = 2'(mb[i]);
    return r;
  endfunction

  task automatic check_state(input string tag);
    chk({tag, ".board"},  s_board, model_board());
    chk({tag, ".turn"},   s_turn,  64'(mturn));
    chk({tag, ".count"},  s_count, 64'(mcount));
    chk({tag, ".over"},   s_go,    64'(mover));
    chk({tag, ".winner"}, s_win,   64'(mwinner));
    chk({tag, ".draw"},   s_draw,  64'(mdraw));
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic do_reset();
    clr = 1'b1;
    tb_valid = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    model_reset(use4 ? 4 : 3);
  endtask

  // res: 1 ack, 0 reject, -1 no answer
  task automatic do_move(input int idx, output int res);
    int exp_res, lat;
    tb_valid = 1'b1;
    tb_idx   = 4'(idx);
    res      = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (s_ack || s_rej) begin
        chk("ack_reject_exclusive", 64'(s_ack & s_rej), 64'd0);
        res = s_ack ? 1 : 0;
        break;
      end
    end
    tb_valid = 1'b0;
    if (res < 0) timeout_fail("move_handshake");
    exp_res = model_move(idx);
    chk("move_result", 64'(res), 64'(exp_res));
    if (res == 1) begin
      lat = 0;
      for (int i = 0; i < 40; i++) begin
        if (!s_rdy && !s_go) lat++;
        else break;
        @(negedge clk);
        if (i == 0) chk("ack_pulse_width", s_ack, 64'd0);
      end
      chk("scan_latency", 64'(lat), 64'(2 * mn + 2));
    end else if (res == 0) begin
      @(negedge clk);
      chk("reject_pulse_width", s_rej, 64'd0);
    end
    check_state("after_move");
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit       do_clr;
    int       idx;
    bit       exp_ack;
    bit       exp_over;
    logic [1:0] exp_winner;
    bit       exp_draw;
    int       exp_count;
    bit       exp_turn;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit c, input int idx, input bit a, input bit o,
                              input logic [1:0] w, input bit d, input int n, input bit t);
    vec_t v;
    v.do_clr = c; v.idx = idx; v.exp_ack = a; v.exp_over = o;
    v.exp_winner = w; v.exp_draw = d; v.exp_count = n; v.exp_turn = t;
    return v;
  endfunction

  initial begin
    int res, cyc, pulses, idx;
    bit got;

    clr = 1'b1; tb_valid = 1'b0; tb_idx = '0; use4 = 1'b0;

    // Accept, illegal cell, out-of-range index
    vecs.push_back(mk(1, 4, 1, 0, 2'b00, 0, 1, 1));
    vecs.push_back(mk(0, 4, 0, 0, 2'b00, 0, 1, 1));
    vecs.push_back(mk(0, 9, 0, 0, 2'b00, 0, 1, 1));
    vecs.push_back(mk(0, 15, 0, 0, 2'b00, 0, 1, 1));
    // Player 1 wins on row 0
    vecs.push_back(mk(1, 0, 1, 0, 2'b00, 0, 1, 1));
    vecs.push_back(mk(0, 3, 1, 0, 2'b00, 0, 2, 0));
    vecs.push_back(mk(0, 1, 1, 0, 2'b00, 0, 3, 1));
    vecs.push_back(mk(0, 4, 1, 0, 2'b00, 0, 4, 0));
    vecs.push_back(mk(0, 2, 1, 1, 2'b01, 0, 5, 0));
    vecs.push_back(mk(0, 5, 0, 1, 2'b01, 0, 5, 0));
    // Draw
    vecs.push_back(mk(1, 0, 1, 0, 2'b00, 0, 1, 1));
    vecs.push_back(mk(0, 1, 1, 0, 2'b00, 0, 2, 0));
    vecs.push_back(mk(0, 2, 1, 0, 2'b00, 0, 3, 1));
    vecs.push_back(mk(0, 4, 1, 0, 2'b00, 0, 4, 0));
    vecs.push_back(mk(0, 3, 1, 0, 2'b00, 0, 5, 1));
    vecs.push_back(mk(0, 5, 1, 0, 2'b00, 0, 6, 0));
    vecs.push_back(mk(0, 7, 1, 0, 2'b00, 0, 7, 1));
    vecs.push_back(mk(0, 6, 1, 0, 2'b00, 0, 8, 0));
    vecs.push_back(mk(0, 8, 1, 1, 2'b00, 1, 9, 0));
    vecs.push_back(mk(0, 4, 0, 1, 2'b00, 1, 9, 0));

    repeat (2) @(negedge clk);
    clr = 1'b0;
    model_reset(3);

    // Reset state
    chk("reset.board", s_board, 64'd0);
    chk("reset.turn",  s_turn,  64'd0);
    chk("reset.count", s_count, 64'd0);
    chk("reset.ready", s_rdy,   64'd1);
    chk("reset.over",  s_go,    64'd0);
    chk("reset.ack",   s_ack,   64'd0);
    chk("reset.rej",   s_rej,   64'd0);
    chk("reset.winner", s_win,  64'd0);
    chk("reset.draw",  s_draw,  64'd0);

    // Table-driven sequences on N=3
    foreach (vecs[n]) begin
      if (vecs[n].do_clr) do_reset();
      do_move(vecs[n].idx, res);
      chk("vec.ack",    64'(res),    64'(vecs[n].exp_ack));
      chk("vec.over",   s_go,        64'(vecs[n].exp_over));
      chk("vec.winner", s_win,       64'(vecs[n].exp_winner));
      chk("vec.draw",   s_draw,      64'(vecs[n].exp_draw));
      chk("vec.count",  s_count,     64'(vecs[n].exp_count));
      chk("vec.turn",   s_turn,      64'(vecs[n].exp_turn));
    end

    // Request held through SCAN gets neither ack nor reject until IDLE
    do_reset();
    tb_valid = 1'b1; tb_idx = 4'd0;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (s_ack) begin got = 1; break; end
    end
    if (!got) timeout_fail("scan_ignore.first_ack");
    void'(model_move(0));
    tb_idx = 4'd5;
    cyc = 0; pulses = 0; got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (s_rej) pulses++;
      if (s_ack) begin got = 1; break; end
    end
    tb_valid = 1'b0;
    if (!got) timeout_fail("scan_ignore.second_ack");
    chk("scan_ignore.cycles_to_ack", 64'(cyc), 64'(2 * 3 + 2 + 1));
    chk("scan_ignore.rejects", 64'(pulses), 64'd0);
    void'(model_move(5));
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (s_rdy) begin got = 1; break; end
    end
    if (!got) timeout_fail("scan_ignore.ready");
    check_state("scan_ignore");

    // clr three cycles after an ack aborts the scan with no result
    do_reset();
    tb_valid = 1'b1; tb_idx = 4'd4;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (s_ack) begin got = 1; break; end
    end
    tb_valid = 1'b0;
    if (!got) timeout_fail("clr_scan.ack");
    repeat (2) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_reset(3);
    chk("clr_scan.ready", s_rdy, 64'd1);
    check_state("clr_scan");
    repeat (12) @(negedge clk);
    chk("clr_scan.ready_later", s_rdy, 64'd1);
    check_state("clr_scan_later");

    // N=4: anti-diagonal win for player 1
    use4 = 1'b1;
    do_reset();
    foreach (vecs[n]) begin end
    do_move(3, res);  do_move(0, res);
    do_move(6, res);  do_move(1, res);
    do_move(9, res);  do_move(2, res);
    do_move(12, res);
    chk("n4.over",   s_go,    64'd1);
    chk("n4.winner", s_win,   64'd1);
    chk("n4.count",  s_count, 64'd7);
    do_move(15, res);
    chk("n4.over_reject", 64'(res), 64'd0);

    // Random games on both sizes
    for (int g = 0; g < 10; g++) begin
      use4 = (g >= 6);
      do_reset();
      for (int k = 0; k < 40; k++) begin
        if (mover != 0) break;
        idx = $urandom_range(0, 15);
        do_move(idx, res);
      end
      idx = $urandom_range(0, 15);
      if (mover != 0) do_move(idx, res);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
